// File: rtl/eco32f_divider_if.sv
// Execute-stage <-> divider handshake: decoded op flags and operands in, stall/result/exception out.
// The execute stage takes the master side; the divider takes the slave side.
interface eco32f_divider_if;
  logic        ex_op_div;
  logic        ex_op_rem;
  logic        ex_signed_div;
  logic [31:0] ex_dividend;
  logic [31:0] ex_divisor;
  logic        ex_advance;
  logic        ex_flush;
  logic        div_stall;
  logic [31:0] div_result;
  logic        div_done;
  logic        div_exc_zero;

  modport master (
    output ex_op_div, ex_op_rem, ex_signed_div, ex_dividend, ex_divisor, ex_advance, ex_flush,
    input  div_stall, div_result, div_done, div_exc_zero
  );

  modport slave (
    input  ex_op_div, ex_op_rem, ex_signed_div, ex_dividend, ex_divisor, ex_advance, ex_flush,
    output div_stall, div_result, div_done, div_exc_zero
  );
endinterface

// File: rtl/eco32f_divider.sv
// Restoring shift-subtract divide/remainder, one quotient bit per cycle; 33 stalled cycles per op,
// 1 for divide-by-zero. Result is held in DONE until execute advances; flush aborts from any state.
module eco32f_divider (
  input  logic             clk,
  input  logic             rst,
  eco32f_divider_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t      state, state_nxt;
  logic        req, start, zero_div;
  logic [31:0] x_mag, y_mag;
  logic [31:0] rem, quot, dvs;
  logic [4:0]  count;
  logic        q_neg, r_neg, sel_rem;
  logic [32:0] trial;
  logic        ge;
  logic [31:0] rem_nxt, quot_nxt, q_fin, r_fin;
  logic [31:0] result;
  logic        done, exc_zero;

  assign req = bus.ex_op_div | bus.ex_op_rem;

  assign x_mag = (bus.ex_signed_div && bus.ex_dividend[31]) ? (~bus.ex_dividend + 32'd1) : bus.ex_dividend;
  assign y_mag = (bus.ex_signed_div && bus.ex_divisor[31])  ? (~bus.ex_divisor + 32'd1)  : bus.ex_divisor;

  // trial is 33 bits: doubling a remainder just below a large divisor can carry out of bit 31
  assign trial    = {rem, quot[31]};
  assign ge       = trial[32] | (trial[31:0] >= dvs);
  assign rem_nxt  = ge ? (trial[31:0] - dvs) : trial[31:0];
  assign quot_nxt = {quot[30:0], ge};
  assign q_fin    = q_neg ? (~quot_nxt + 32'd1) : quot_nxt;
  assign r_fin    = r_neg ? (~rem_nxt + 32'd1) : rem_nxt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    start     = 1'b0;
    zero_div  = 1'b0;
    if (bus.ex_flush) begin
      state_nxt = IDLE;
    end else begin
      case (state)
        IDLE: if (req) begin
          if (bus.ex_divisor == 32'd0) begin
            zero_div  = 1'b1;
            state_nxt = DONE;
          end else begin
            start     = 1'b1;
            state_nxt = RUN;
          end
        end
        RUN:  if (count == 5'd31) state_nxt = DONE;
        DONE: if (bus.ex_advance) state_nxt = IDLE;
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rem      <= '0;
      quot     <= '0;
      dvs      <= '0;
      count    <= '0;
      q_neg    <= 1'b0;
      r_neg    <= 1'b0;
      sel_rem  <= 1'b0;
      result   <= '0;
      done     <= 1'b0;
      exc_zero <= 1'b0;
    end else if (bus.ex_flush) begin
      result   <= '0;
      done     <= 1'b0;
      exc_zero <= 1'b0;
    end else if (zero_div) begin
      result   <= '0;
      done     <= 1'b1;
      exc_zero <= 1'b1;
    end else if (start) begin
      rem     <= '0;
      quot    <= x_mag;
      dvs     <= y_mag;
      count   <= '0;
      q_neg   <= bus.ex_signed_div & (bus.ex_dividend[31] ^ bus.ex_divisor[31]);
      r_neg   <= bus.ex_signed_div & bus.ex_dividend[31];
      sel_rem <= bus.ex_op_rem;
    end else if (state == RUN) begin
      rem   <= rem_nxt;
      quot  <= quot_nxt;
      count <= count + 5'd1;
      if (count == 5'd31) begin
        result <= sel_rem ? r_fin : q_fin;
        done   <= 1'b1;
      end
    end else if (state == DONE && bus.ex_advance) begin
      done     <= 1'b0;
      exc_zero <= 1'b0;
    end
  end

  assign bus.div_stall    = req & (state != DONE) & ~bus.ex_flush;
  assign bus.div_result   = result;
  assign bus.div_done     = done;
  assign bus.div_exc_zero = exc_zero;

endmodule

// File: tb/tb_eco32f_divider.sv
// Scoreboarded bench for eco32f_divider: latency, arithmetic corner cases, flush, reset, DONE hold.
module tb_eco32f_divider;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  eco32f_divider_if bus ();

  eco32f_divider dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    logic [31:0] res;
    logic        exc;
    int          stalls;
  } exp_t;

  exp_t exp_q[$];
  int   errors = 0;
  int   checks = 0;

  function automatic logic [31:0] model(input logic rem_op, input logic sgn,
                                        input logic [31:0] x, input logic [31:0] y);
    logic [31:0] r;
    if (sgn && x == 32'h8000_0000 && y == 32'hFFFF_FFFF)
      r = rem_op ? 32'd0 : 32'h8000_0000;
    else if (sgn)
      r = rem_op ? $signed(x) % $signed(y) : $signed(x) / $signed(y);
    else
      r = rem_op ? x % y : x / y;
    return r;
  endfunction

  task automatic set_inputs(input logic d, input logic r, input logic s,
                            input logic [31:0] x, input logic [31:0] y, input logic adv);
    bus.ex_op_div     = d;
    bus.ex_op_rem     = r;
    bus.ex_signed_div = s;
    bus.ex_dividend   = x;
    bus.ex_divisor    = y;
    bus.ex_advance    = adv;
  endtask

  task automatic push_exp(input logic r, input logic s, input logic [31:0] x, input logic [31:0] y);
    exp_t e;
    if (y == 32'd0) begin
      e.res = 32'd0; e.exc = 1'b1; e.stalls = 1;
    end else begin
      e.res = model(r, s, x, y); e.exc = 1'b0; e.stalls = 33;
    end
    exp_q.push_back(e);
  endtask

  // Counts stalled cycles from the current one until div_done, then checks against the scoreboard.
  task automatic wait_result(input string name);
    int   n  = 0;
    int   st = 0;
    exp_t e;
    while (n < 200) begin
      @(negedge clk);
      if (bus.div_done) break;
      if (bus.div_stall) st++;
      n++;
    end
    e = exp_q.pop_front();
    checks++;
    if (bus.div_done !== 1'b1) begin
      errors++; $display("FAIL %s timeout: div_done=%b want 1", name, bus.div_done);
    end
    checks++;
    if (bus.div_result !== e.res) begin
      errors++; $display("FAIL %s result: got %h want %h", name, bus.div_result, e.res);
    end
    checks++;
    if (bus.div_exc_zero !== e.exc) begin
      errors++; $display("FAIL %s exc_zero: got %b want %b", name, bus.div_exc_zero, e.exc);
    end
    checks++;
    if (st != e.stalls) begin
      errors++; $display("FAIL %s stall cycles: got %0d want %0d", name, st, e.stalls);
    end
    checks++;
    if (bus.div_stall !== 1'b0) begin
      errors++; $display("FAIL %s stall in done: got %b want 0", name, bus.div_stall);
    end
  endtask

  task automatic do_op(input string name, input logic d, input logic r, input logic s,
                       input logic [31:0] x, input logic [31:0] y);
    @(posedge clk); #1;
    set_inputs(d, r, s, x, y, 1'b1);
    push_exp(r, s, x, y);
    wait_result(name);
  endtask

  task automatic go_idle();
    @(posedge clk); #1;
    set_inputs(1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 1'b1);
  endtask

  task automatic check_outputs_zero(input string name);
    checks++;
    if ({bus.div_stall, bus.div_done, bus.div_exc_zero, bus.div_result} !== 35'd0) begin
      errors++;
      $display("FAIL %s: stall=%b done=%b exc=%b result=%h want all 0",
               name, bus.div_stall, bus.div_done, bus.div_exc_zero, bus.div_result);
    end
  endtask

  task automatic test_reset();
    rst = 1'b0;
    bus.ex_flush = 1'b0;
    set_inputs(1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 1'b0);
    repeat (3) @(negedge clk);
    check_outputs_zero("reset_held");
    rst = 1'b1;
    @(negedge clk);
    check_outputs_zero("reset_released");
  endtask

  task automatic test_divu_basic();
    do_op("divu_100_7", 1'b1, 1'b0, 1'b0, 32'd100, 32'd7);
    go_idle();
    @(negedge clk);
    checks++;
    if (bus.div_done !== 1'b0) begin
      errors++; $display("FAIL divu_idle_after: div_done=%b want 0", bus.div_done);
    end
  endtask

  task automatic test_signed_and_corners();
    do_op("rem_m7_2",   1'b0, 1'b1, 1'b1, 32'hFFFF_FFF9, 32'd2);
    do_op("div_m7_2",   1'b1, 1'b0, 1'b1, 32'hFFFF_FFF9, 32'd2);
    do_op("divu_max_2", 1'b1, 1'b0, 1'b0, 32'hFFFF_FFFF, 32'd2);
    do_op("div_ovf",    1'b1, 1'b0, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF);
    do_op("rem_ovf",    1'b0, 1'b1, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF);
    do_op("divu_big",   1'b1, 1'b0, 1'b0, 32'hFFFF_FFFE, 32'hFFFF_FFFF);
    go_idle();
  endtask

  task automatic test_div_zero();
    do_op("div_5_0", 1'b1, 1'b0, 1'b1, 32'd5, 32'd0);
    go_idle();
    @(negedge clk);
    checks++;
    if (bus.div_exc_zero !== 1'b0) begin
      errors++; $display("FAIL div0_exc_cleared: got %b want 0", bus.div_exc_zero);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 8; i++) begin
      logic [31:0] x, y;
      x = $urandom;
      y = $urandom >> $urandom_range(0, 28);
      if (y == 32'd0) y = 32'd3;
      do_op("random", ~i[1], i[1], i[0], x, y);
    end
    go_idle();
  endtask

  task automatic test_back_to_back();
    do_op("b2b_first",  1'b1, 1'b0, 1'b0, 32'd77, 32'd5);
    do_op("b2b_second", 1'b0, 1'b1, 1'b0, 32'd77, 32'd5);
    go_idle();
  endtask

  task automatic test_flush();
    @(posedge clk); #1;
    set_inputs(1'b1, 1'b0, 1'b0, 32'd1000, 32'd3, 1'b1);
    repeat (10) @(posedge clk);
    #1 bus.ex_flush = 1'b1;
    @(negedge clk);
    checks++;
    if (bus.div_stall !== 1'b0) begin
      errors++; $display("FAIL flush_stall: got %b want 0", bus.div_stall);
    end
    @(posedge clk); #1;
    bus.ex_flush = 1'b0;
    set_inputs(1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 1'b1);
    @(negedge clk);
    checks++;
    if (bus.div_done !== 1'b0 || bus.div_stall !== 1'b0) begin
      errors++; $display("FAIL flush_idle: done=%b stall=%b want 0 0", bus.div_done, bus.div_stall);
    end
    do_op("after_flush_9_3", 1'b1, 1'b0, 1'b0, 32'd9, 32'd3);
    go_idle();
  endtask

  task automatic test_reset_mid_run();
    @(posedge clk); #1;
    set_inputs(1'b1, 1'b0, 1'b0, 32'd50, 32'd5, 1'b1);
    repeat (20) @(posedge clk);
    #1;
    rst = 1'b0;
    set_inputs(1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 1'b1);
    #1 check_outputs_zero("reset_async");
    @(negedge clk);
    check_outputs_zero("reset_mid_run");
    @(posedge clk); #1 rst = 1'b1;
    repeat (3) begin
      @(negedge clk);
      checks++;
      if (bus.div_done !== 1'b0) begin
        errors++; $display("FAIL reset_no_done: got %b want 0", bus.div_done);
      end
    end
  endtask

  task automatic test_done_hold();
    @(posedge clk); #1;
    set_inputs(1'b1, 1'b0, 1'b0, 32'd40, 32'd8, 1'b0);
    push_exp(1'b0, 1'b0, 32'd40, 32'd8);
    wait_result("hold_40_8");
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checks++;
      if (bus.div_done !== 1'b1 || bus.div_result !== 32'd5 || bus.div_stall !== 1'b0) begin
        errors++;
        $display("FAIL done_hold: done=%b result=%h stall=%b want 1 00000005 0",
                 bus.div_done, bus.div_result, bus.div_stall);
      end
    end
    @(posedge clk); #1;
    set_inputs(1'b1, 1'b0, 1'b0, 32'd8, 32'd2, 1'b1);
    push_exp(1'b0, 1'b0, 32'd8, 32'd2);
    @(posedge clk);
    wait_result("advance_8_2");
    go_idle();
  endtask

  initial begin
    test_reset();
    test_divu_basic();
    test_signed_and_corners();
    test_div_zero();
    test_random();
    test_back_to_back();
    test_flush();
    test_reset_mid_run();
    test_done_hold();
    repeat (2) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
